// File: rtl/change_dispenser_pkg.sv
// Shared constants and state encodings for the change dispenser.
// Coin values, denomination indices and FSM/timer state types.
package change_dispenser_pkg;

    localparam logic [4:0] NICKEL_C  = 5'd5;
    localparam logic [4:0] DIME_C    = 5'd10;
    localparam logic [4:0] QUARTER_C = 5'd25;

    localparam logic [1:0] D_NICK  = 2'd0;
    localparam logic [1:0] D_DIME  = 2'd1;
    localparam logic [1:0] D_QUART = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT_SENSE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_PULSE,
        T_ACK
    } tphase_t;

    function automatic logic [4:0] coin_value(input logic [1:0] d);
        case (d)
            D_QUART: return QUARTER_C;
            D_DIME:  return DIME_C;
            default: return NICKEL_C;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/status and hopper-side signals of the change dispenser.
// master = vending machine / hopper environment, slave = dispenser.
interface change_dispenser_if #(
    parameter int CNT_W   = 5,
    parameter int SHORT_W = 11
);
    logic               load;
    logic [CNT_W-1:0]   quart_in;
    logic [CNT_W-1:0]   dim_in;
    logic [CNT_W-1:0]   nick_in;
    logic [2:0]         hopper_empty;
    logic               coin_sensed;
    logic               ready;
    logic [2:0]         eject;
    logic               done;
    logic [SHORT_W-1:0] shortfall;
    logic               fault;

    modport master (
        output load, quart_in, dim_in, nick_in, hopper_empty, coin_sensed,
        input  ready, eject, done, shortfall, fault
    );

    modport slave (
        input  load, quart_in, dim_in, nick_in, hopper_empty, coin_sensed,
        output ready, eject, done, shortfall, fault
    );

endinterface

// File: rtl/change_dispenser_hopper_timer.sv
// Per-coin timer: counts the solenoid pulse, then the sensor acknowledge window.
// Returns to idle on coin_sensed, on timeout, or on rst.
module hopper_timer
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic coin_sensed,
    output logic pulse_active,
    output logic pulse_last,
    output logic timeout
);
    localparam int TMAX = (PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    tphase_t       phase;
    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= T_IDLE;
            cnt   <= '0;
        end else begin
            case (phase)
                T_IDLE: begin
                    if (start) begin
                        phase <= T_PULSE;
                        cnt   <= TW'(PULSE_CYCLES - 1);
                    end
                end
                T_PULSE: begin
                    if (cnt == '0) begin
                        phase <= T_ACK;
                        cnt   <= TW'(ACK_TIMEOUT - 1);
                    end else begin
                        cnt <= cnt - TW'(1);
                    end
                end
                T_ACK: begin
                    if (coin_sensed || cnt == '0) begin
                        phase <= T_IDLE;
                    end else begin
                        cnt <= cnt - TW'(1);
                    end
                end
                default: phase <= T_IDLE;
            endcase
        end
    end

    assign pulse_active = (phase == T_PULSE);
    assign pulse_last   = (phase == T_PULSE) && (cnt == '0);
    assign timeout      = (phase == T_ACK) && (cnt == '0) && !coin_sensed;

endmodule

// File: rtl/change_dispenser.sv
// Pays out quarter/dime/nickel counts one coin at a time with sensor confirmation.
// Optional feature: define CHANGE_SUBSTITUTE_EN to replace empty/jammed coins with smaller ones.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int CNT_W        = 5,
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 16,
    parameter int SHORT_W      = 11
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);
`ifdef CHANGE_SUBSTITUTE_EN
    // substitution can stack quarters and dimes onto the nickel count
    localparam int CW = CNT_W + 3;
`else
    localparam int CW = CNT_W + 2;
`endif

    state_t             state, state_n;
    logic [CW-1:0]      cnt   [3];
    logic [CW-1:0]      cnt_n [3];
    logic [2:0]         jam, jam_n;
    logic [1:0]         d, d_n, sel;
    logic [SHORT_W-1:0] short_r, short_n;
    logic               fault_r, fault_n;
    logic               any, start;
    logic               pulse_active, pulse_last, timeout;

    hopper_timer #(
        .PULSE_CYCLES (PULSE_CYCLES),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .coin_sensed  (bus.coin_sensed),
        .pulse_active (pulse_active),
        .pulse_last   (pulse_last),
        .timeout      (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '{default: '0};
            jam     <= '0;
            d       <= D_NICK;
            short_r <= '0;
            fault_r <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            jam     <= jam_n;
            d       <= d_n;
            short_r <= short_n;
            fault_r <= fault_n;
        end
    end

    always_comb begin
        sel = D_NICK;
        if (cnt[D_QUART] != '0)     sel = D_QUART;
        else if (cnt[D_DIME] != '0) sel = D_DIME;
        any = (cnt[D_QUART] | cnt[D_DIME] | cnt[D_NICK]) != '0;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        jam_n   = jam;
        d_n     = d;
        short_n = short_r;
        fault_n = fault_r;
        start   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.load) begin
                    cnt_n[D_QUART] = CW'(bus.quart_in);
                    cnt_n[D_DIME]  = CW'(bus.dim_in);
                    cnt_n[D_NICK]  = CW'(bus.nick_in);
                    short_n        = '0;
                    state_n        = S_SELECT;
                end
            end
            S_SELECT: begin
                if (!any) begin
                    state_n = S_DONE;
                end else if (bus.hopper_empty[sel] || jam[sel]) begin
`ifdef CHANGE_SUBSTITUTE_EN
                    if (sel == D_QUART) begin
                        cnt_n[D_DIME] = cnt[D_DIME] + (cnt[D_QUART] << 1);
                        cnt_n[D_NICK] = cnt[D_NICK] + cnt[D_QUART];
                    end else if (sel == D_DIME) begin
                        cnt_n[D_NICK] = cnt[D_NICK] + (cnt[D_DIME] << 1);
                    end else begin
                        short_n = short_r + SHORT_W'(cnt[sel]) * SHORT_W'(coin_value(sel));
                    end
`else
                    short_n = short_r + SHORT_W'(cnt[sel]) * SHORT_W'(coin_value(sel));
`endif
                    cnt_n[sel] = '0;
                end else begin
                    d_n     = sel;
                    start   = 1'b1;
                    state_n = S_EJECT;
                end
            end
            S_EJECT: begin
                if (pulse_last) state_n = S_WAIT_SENSE;
            end
            S_WAIT_SENSE: begin
                if (bus.coin_sensed) begin
                    cnt_n[d] = cnt[d] - CW'(1);
                    state_n  = S_SELECT;
                end else if (timeout) begin
                    fault_n = 1'b1;
                    jam_n[d] = 1'b1;
`ifndef CHANGE_SUBSTITUTE_EN
                    short_n  = short_r + SHORT_W'(cnt[d]) * SHORT_W'(coin_value(d));
                    cnt_n[d] = '0;
`endif
                    // with substitution the remaining count, in-flight coin included,
                    // is converted by SELECT now that the hopper is marked jammed
                    state_n = S_SELECT;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.ready     = (state == S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.eject     = (state == S_EJECT && pulse_active) ? (3'b001 << d) : 3'b000;
    assign bus.shortfall = short_r;
    assign bus.fault     = fault_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected eject pulses are queued per request
// and matched as each pulse ends; per-scenario tasks check timing, shortfall and fault.
module tb_change_dispenser;

    localparam int CNT_W   = 5;
    localparam int SHORT_W = 11;
    localparam int PULSE   = 4;
    localparam int ACK_TO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    change_dispenser_if #(.CNT_W(CNT_W), .SHORT_W(SHORT_W)) bus ();

    change_dispenser #(
        .CNT_W        (CNT_W),
        .PULSE_CYCLES (PULSE),
        .ACK_TIMEOUT  (ACK_TO),
        .SHORT_W      (SHORT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] exp_q[$];
    logic       sense_auto = 1'b0;
    logic       stray      = 1'b0;
    logic       resp_en    = 1'b1;
    int         resp_delay = 3;
    int         pulses_done = 0;

    logic [2:0] prev_ej  = 3'b000;
    int         ej_len   = 0;
    int         sense_cd = 0;

    assign bus.coin_sensed = sense_auto | stray;

    // eject monitor + sensor model: answers resp_delay cycles into WAIT_SENSE
    always @(negedge clk) begin
        logic [2:0] e;
        sense_auto = 1'b0;
        if (rst) begin
            prev_ej  = 3'b000;
            ej_len   = 0;
            sense_cd = 0;
        end else begin
            if (bus.eject != 3'b000) begin
                if (prev_ej == 3'b000) ej_len = 1;
                else ej_len++;
            end else if (prev_ej != 3'b000) begin
                pulses_done++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL eject_unexpected: got eject=%b len=%0d, expected no pulse", prev_ej, ej_len);
                end else begin
                    e = exp_q.pop_front();
                    if (prev_ej !== e || ej_len != PULSE) begin
                        n_err++;
                        $display("FAIL eject_pulse: got eject=%b len=%0d, expected eject=%b len=%0d",
                                 prev_ej, ej_len, e, PULSE);
                    end
                end
                if (resp_en) sense_cd = resp_delay;
            end
            if (sense_cd > 0) begin
                sense_cd--;
                if (sense_cd == 0) sense_auto = 1'b1;
            end
            prev_ej = bus.eject;
        end
    end

    task automatic do_load(input int q, input int dd, input int n);
        bus.quart_in = CNT_W'(q);
        bus.dim_in   = CNT_W'(dd);
        bus.nick_in  = CNT_W'(n);
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
        n_cmp++;
        if (bus.eject !== 3'b000) begin n_err++; $display("FAIL reset_eject: got %b want 000", bus.eject); end
        n_cmp++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++;
        if (bus.shortfall !== 11'd0) begin n_err++; $display("FAIL reset_shortfall: got %0d want 0", bus.shortfall); end
        n_cmp++;
        if (bus.fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_order();
        int cyc;
        resp_en = 1'b1; resp_delay = 3; bus.hopper_empty = 3'b000;
        exp_q.push_back(3'b100); exp_q.push_back(3'b100);
        exp_q.push_back(3'b010); exp_q.push_back(3'b001);
        do_load(2, 1, 1);
        n_cmp++;
        if (bus.ready !== 1'b0) begin n_err++; $display("FAIL basic_busy: got ready=%b want 0", bus.ready); end
        wait_done(200, cyc);
        n_cmp++;
        if (cyc != 4 * (1 + PULSE + 3) + 2) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", cyc, 4 * (1 + PULSE + 3) + 2); end
        n_cmp++;
        if (bus.shortfall !== 11'd0) begin n_err++; $display("FAIL basic_shortfall: got %0d want 0", bus.shortfall); end
        n_cmp++;
        if (bus.fault !== 1'b0) begin n_err++; $display("FAIL basic_fault: got %b want 0", bus.fault); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_pending: got %0d pulses outstanding want 0", exp_q.size()); end
        @(negedge clk);
        n_cmp++;
        if ({bus.done, bus.ready} !== 2'b01) begin n_err++; $display("FAIL basic_after_done: got done,ready=%b want 01", {bus.done, bus.ready}); end
    endtask

    task automatic test_zero_request();
        int cyc, p0;
        p0 = pulses_done;
        do_load(0, 0, 0);
        wait_done(20, cyc);
        n_cmp++;
        if (cyc != 2) begin n_err++; $display("FAIL zero_latency: got %0d want 2", cyc); end
        n_cmp++;
        if (bus.shortfall !== 11'd0) begin n_err++; $display("FAIL zero_shortfall: got %0d want 0", bus.shortfall); end
        @(negedge clk);
        n_cmp++;
        if (pulses_done != p0) begin n_err++; $display("FAIL zero_no_eject: got %0d pulses want 0", pulses_done - p0); end
        n_cmp++;
        if ({bus.done, bus.ready} !== 2'b01) begin n_err++; $display("FAIL zero_after_done: got done,ready=%b want 01", {bus.done, bus.ready}); end
    endtask

    task automatic test_empty_hopper();
        int cyc, exp_cyc, exp_short;
        bus.hopper_empty = 3'b100;
`ifdef CHANGE_SUBSTITUTE_EN
        for (int i = 0; i < 7; i++) exp_q.push_back(3'b010);
        for (int i = 0; i < 3; i++) exp_q.push_back(3'b001);
        exp_cyc = 1 + 10 * (1 + PULSE + 3) + 2;
        exp_short = 0;
`else
        exp_q.push_back(3'b010);
        exp_cyc = 1 + (1 + PULSE + 3) + 2;
        exp_short = 75;
`endif
        do_load(3, 1, 0);
        wait_done(400, cyc);
        n_cmp++;
        if (cyc != exp_cyc) begin n_err++; $display("FAIL empty_latency: got %0d want %0d", cyc, exp_cyc); end
        n_cmp++;
        if (bus.shortfall !== SHORT_W'(exp_short)) begin n_err++; $display("FAIL empty_shortfall: got %0d want %0d", bus.shortfall, exp_short); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL empty_pending: got %0d pulses outstanding want 0", exp_q.size()); end
        @(negedge clk);
        bus.hopper_empty = 3'b000;
    endtask

    task automatic test_jam();
        int cyc, exp_cyc, p0;
        resp_en = 1'b0;
        exp_q.push_back(3'b001);
`ifdef CHANGE_SUBSTITUTE_EN
        exp_cyc = 1 + PULSE + ACK_TO + 3;
`else
        exp_cyc = 1 + PULSE + ACK_TO + 2;
`endif
        do_load(0, 0, 2);
        wait_done(200, cyc);
        n_cmp++;
        if (cyc != exp_cyc) begin n_err++; $display("FAIL jam_latency: got %0d want %0d", cyc, exp_cyc); end
        n_cmp++;
        if (bus.fault !== 1'b1) begin n_err++; $display("FAIL jam_fault: got %b want 1", bus.fault); end
        n_cmp++;
        if (bus.shortfall !== 11'd10) begin n_err++; $display("FAIL jam_shortfall: got %0d want 10", bus.shortfall); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL jam_pending: got %0d pulses outstanding want 0", exp_q.size()); end
        @(negedge clk);
        resp_en = 1'b1;
        p0 = pulses_done;
        do_load(0, 0, 1);
        wait_done(50, cyc);
        n_cmp++;
        if (bus.shortfall !== 11'd5) begin n_err++; $display("FAIL jam_sticky_shortfall: got %0d want 5", bus.shortfall); end
        n_cmp++;
        if (bus.fault !== 1'b1) begin n_err++; $display("FAIL jam_sticky_fault: got %b want 1", bus.fault); end
        @(negedge clk);
        n_cmp++;
        if (pulses_done != p0) begin n_err++; $display("FAIL jam_sticky_eject: got %0d pulses want 0", pulses_done - p0); end
    endtask

    task automatic test_reset_mid_payout();
        int cyc, p0, k, dones;
        resp_en = 1'b1; resp_delay = 3;
        p0 = pulses_done;
        exp_q.push_back(3'b100);
        do_load(3, 0, 0);
        k = 0;
        while (!(pulses_done >= p0 + 1 && bus.eject != 3'b000) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 100) begin n_err++; $display("FAIL rstmid_second_pulse: got no second pulse in %0d cycles want one", k); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.eject !== 3'b000) begin n_err++; $display("FAIL rstmid_eject: got %b want 000", bus.eject); end
        n_cmp++;
        if (bus.ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", bus.ready); end
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        n_cmp++;
        if (dones != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d done pulses want 0", dones); end
        n_cmp++;
        if (bus.fault !== 1'b0) begin n_err++; $display("FAIL rstmid_fault_cleared: got %b want 0", bus.fault); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rstmid_pending: got %0d pulses outstanding want 0", exp_q.size()); end
        exp_q.push_back(3'b100);
        do_load(1, 0, 0);
        wait_done(100, cyc);
        n_cmp++;
        if (cyc != (1 + PULSE + 3) + 2) begin n_err++; $display("FAIL rstmid_reload_latency: got %0d want %0d", cyc, (1 + PULSE + 3) + 2); end
        n_cmp++;
        if (bus.shortfall !== 11'd0) begin n_err++; $display("FAIL rstmid_reload_shortfall: got %0d want 0", bus.shortfall); end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int cyc, p0;
        resp_en = 1'b1; resp_delay = 3;
        p0 = pulses_done;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.ready, bus.eject, bus.done} !== 5'b10000) begin n_err++; $display("FAIL stray_idle: got ready,eject,done=%b want 10000", {bus.ready, bus.eject, bus.done}); end
        exp_q.push_back(3'b100); exp_q.push_back(3'b010);
        do_load(1, 1, 0);
        bus.quart_in = 5'd5; bus.dim_in = 5'd5; bus.nick_in = 5'd5;
        bus.load = 1'b1;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        bus.load = 1'b0;
        wait_done(200, cyc);
        if (cyc > 0) cyc += 2;
        n_cmp++;
        if (cyc != 2 * (1 + PULSE + 3) + 2) begin n_err++; $display("FAIL busy_latency: got %0d want %0d", cyc, 2 * (1 + PULSE + 3) + 2); end
        n_cmp++;
        if (bus.shortfall !== 11'd0) begin n_err++; $display("FAIL busy_shortfall: got %0d want 0", bus.shortfall); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL busy_pending: got %0d pulses outstanding want 0", exp_q.size()); end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (pulses_done != p0 + 2) begin n_err++; $display("FAIL busy_pulse_count: got %0d want 2", pulses_done - p0); end
    endtask

    initial begin
        bus.load         = 1'b0;
        bus.quart_in     = '0;
        bus.dim_in       = '0;
        bus.nick_in      = '0;
        bus.hopper_empty = 3'b000;
        test_reset();
        test_basic_order();
        test_zero_request();
        test_empty_hopper();
        test_jam();
        test_reset_mid_payout();
        test_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
